// File: rtl/video_timing_gen.sv
// Single-clock video timing generator: h/v counters, sync/de decode with a DELAY-stage
// output pipe, frame counter and start-of-frame strobe. VTG_PATTERN_EN adds colour-bar outputs.
module video_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int DELAY    = 2,
    parameter int CW       = 11,
    parameter int FW       = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_active,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic          o_sof,
    output logic [FW-1:0] o_frame
`ifdef VTG_PATTERN_EN
    ,
    output logic [4:0]    o_r,
    output logic [5:0]    o_g,
    output logic [4:0]    o_b
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);

    if (DELAY > 8) begin : g_err_delay
        $error("video_timing_gen: DELAY must be 0..8");
    end
    if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_err_cw
        $error("video_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
    end
    if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_err_zero
        $error("video_timing_gen: H_SYNC/V_SYNC/H_ACTIVE/V_ACTIVE must be non-zero");
    end

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic [FW-1:0] r_frame;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_run;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h     <= '0;
            r_v     <= '0;
            r_frame <= '0;
        end else if (!i_en) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_wrap ? '0 : r_h + 1'b1;
            if (w_h_wrap) begin
                r_v <= w_v_wrap ? '0 : r_v + 1'b1;
                if (w_v_wrap) r_frame <= r_frame + 1'b1;
            end
        end
    end

    // Timed signals read inactive while held or in reset, so the strobe stays a single clock.
    assign w_run = i_en & i_rst_n;

    logic w_hs_t, w_vs_t, w_de_t;
    assign w_hs_t = w_run & (r_h >= HS_BEG) & (r_h < HS_END);
    assign w_vs_t = w_run & (r_v >= VS_BEG) & (r_v < VS_END);
    assign w_de_t = w_run & (r_h < H_ACT_C) & (r_v < V_ACT_C);

    assign o_x      = r_h;
    assign o_y      = r_v;
    assign o_active = w_de_t;
    assign o_sof    = w_run & (r_h == '0) & (r_v == '0);
    assign o_frame  = r_frame;

`ifdef VTG_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int PW    = 19;

    logic [CW-1:0] w_bar_q;
    logic [2:0]    w_bar;
    logic [15:0]   w_rgb_t;

    assign w_bar_q = r_h / CW'(BAR_W);
    assign w_bar   = (w_bar_q > CW'(7)) ? 3'd7 : w_bar_q[2:0];
    // Bar order white..black maps to: R when bar[1]=0, G when bar[2]=0, B when bar[0]=0.
    assign w_rgb_t = {{5{~w_bar[1]}}, {6{~w_bar[2]}}, {5{~w_bar[0]}}};
`else
    localparam int PW = 3;
`endif

    logic [PW-1:0] w_pipe_in;
    logic [PW-1:0] w_pipe_out;

`ifdef VTG_PATTERN_EN
    assign w_pipe_in = {w_rgb_t, w_de_t, w_vs_t, w_hs_t};
`else
    assign w_pipe_in = {w_de_t, w_vs_t, w_hs_t};
`endif

    if (DELAY == 0) begin : g_nodly
        assign w_pipe_out = w_pipe_in;
    end else begin : g_dly
        logic [DELAY-1:0][PW-1:0] r_vld_pipe;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= w_pipe_in;
                for (int i = 1; i < DELAY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end

        assign w_pipe_out = r_vld_pipe[DELAY-1];
    end

    assign o_hsync = HS_POL ? w_pipe_out[0] : ~w_pipe_out[0];
    assign o_vsync = VS_POL ? w_pipe_out[1] : ~w_pipe_out[1];
    assign o_de    = w_pipe_out[2];

`ifdef VTG_PATTERN_EN
    assign o_r = w_pipe_out[2] ? w_pipe_out[18:14] : 5'd0;
    assign o_g = w_pipe_out[2] ? w_pipe_out[13:8]  : 6'd0;
    assign o_b = w_pipe_out[2] ? w_pipe_out[7:3]   : 5'd0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: small-timing instances for frame-level checks, default-timing
// instances for the 525-clock line.
module tb_video_timing_gen;

    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 1;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_en;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 i_clk = ~i_clk;

    logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y, p_x, p_y;
    logic        a_act, a_hs, a_vs, a_de, a_sof;
    logic        b_act, b_hs, b_vs, b_de, b_sof;
    logic        c_act, c_hs, c_vs, c_de, c_sof;
    logic        d_act, d_hs, d_vs, d_de, d_sof;
    logic        p_act, p_hs, p_vs, p_de, p_sof;
    logic [15:0] a_fr, b_fr, c_fr, d_fr, p_fr;
`ifdef VTG_PATTERN_EN
    logic [4:0] a_r, b_r, c_r, d_r, p_r;
    logic [5:0] a_g, b_g, c_g, d_g, p_g;
    logic [4:0] a_b, b_b, c_b, d_b, p_b;
`endif

    video_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                       .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .DELAY(2)) u_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .o_x(a_x), .o_y(a_y), .o_active(a_act),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_sof(a_sof), .o_frame(a_fr)
`ifdef VTG_PATTERN_EN
        , .o_r(a_r), .o_g(a_g), .o_b(a_b)
`endif
    );

    video_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                       .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .DELAY(0)) u_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .o_x(b_x), .o_y(b_y), .o_active(b_act),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_sof(b_sof), .o_frame(b_fr)
`ifdef VTG_PATTERN_EN
        , .o_r(b_r), .o_g(b_g), .o_b(b_b)
`endif
    );

    video_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                       .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .DELAY(3),
                       .HS_POL(1'b1), .VS_POL(1'b1)) u_c (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .o_x(c_x), .o_y(c_y), .o_active(c_act),
        .o_hsync(c_hs), .o_vsync(c_vs), .o_de(c_de), .o_sof(c_sof), .o_frame(c_fr)
`ifdef VTG_PATTERN_EN
        , .o_r(c_r), .o_g(c_g), .o_b(c_b)
`endif
    );

    video_timing_gen #(.DELAY(0)) u_d (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .o_x(d_x), .o_y(d_y), .o_active(d_act),
        .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de), .o_sof(d_sof), .o_frame(d_fr)
`ifdef VTG_PATTERN_EN
        , .o_r(d_r), .o_g(d_g), .o_b(d_b)
`endif
    );

    video_timing_gen u_p (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .o_x(p_x), .o_y(p_y), .o_active(p_act),
        .o_hsync(p_hs), .o_vsync(p_vs), .o_de(p_de), .o_sof(p_sof), .o_frame(p_fr)
`ifdef VTG_PATTERN_EN
        , .o_r(p_r), .o_g(p_g), .o_b(p_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int a_hs_lo = 0, a_vs_lo = 0, a_de_hi = 0, a_sof_n = 0;
        int b_hs_lo = 0, b_de_hi = 0, c_vs_hi = 0, c_hs_hi = 0;
        int p_hs_lo = 0, p_de_hi = 0;
        int b_fall_k = -1, b_fall_x = -1, c_rise_k = -1, c_de_fall_x = -1;
        int d_fall_x = -1, p_fall_x = -1;
        logic pb_hs, pc_hs, pc_de, pd_hs, pp_hs;

        i_rst_n = 1'b0;
        i_en    = 1'b0;
        repeat (3) tick();
        check("rst_x", a_x, 0);
        check("rst_y", a_y, 0);
        check("rst_frame", a_fr, 0);
        check("rst_sof", a_sof, 0);
        check("rst_hsync", a_hs, 1);
        check("rst_vsync", a_vs, 1);
        check("rst_de", a_de, 0);
        check("rst_hsync_pol1", c_hs, 0);
        check("rst_vsync_pol1", c_vs, 0);

        i_rst_n = 1'b1;
        i_en    = 1'b1;
        #1;
        pb_hs = b_hs; pc_hs = c_hs; pc_de = c_de; pd_hs = d_hs; pp_hs = p_hs;
        for (int k = 0; k < 530; k++) begin
            if (k > 0) tick();
            if (k == 0) begin
                check("release_sof", a_sof, 1);
                check("release_x", a_x, 0);
            end
            if (k == 15) check("active_x15", a_act, 1);
            if (k == 16) check("active_x16", a_act, 0);
            if (k == 459) check("frame_before_wrap", a_fr, 1);
            if (k == 461) check("frame_two", a_fr, 2);
            if (k >= 2 && k <= 461) begin
                if (!a_hs) a_hs_lo++;
                if (!a_vs) a_vs_lo++;
                if (a_de)  a_de_hi++;
            end
            if (k <= 459) begin
                if (a_sof) a_sof_n++;
                if (!b_hs) b_hs_lo++;
                if (b_de)  b_de_hi++;
            end
            if (k >= 3 && k <= 462) begin
                if (c_vs) c_vs_hi++;
                if (c_hs) c_hs_hi++;
            end
            if (k >= 2 && k <= 526) begin
                if (!p_hs) p_hs_lo++;
                if (p_de)  p_de_hi++;
            end
            if (k > 0) begin
                if (pb_hs && !b_hs && b_fall_k < 0) begin b_fall_k = k; b_fall_x = int'(b_x); end
                if (!pc_hs && c_hs && c_rise_k < 0) c_rise_k = k;
                if (pc_de && !c_de && c_de_fall_x < 0) c_de_fall_x = int'(c_x);
                if (pd_hs && !d_hs && d_fall_x < 0) d_fall_x = int'(d_x);
                if (pp_hs && !p_hs && p_fall_x < 0) p_fall_x = int'(p_x);
            end
            pb_hs = b_hs; pc_hs = c_hs; pc_de = c_de; pd_hs = d_hs; pp_hs = p_hs;
`ifdef VTG_PATTERN_EN
            if (k == 2)   check("pat_bar0", {p_r, p_g, p_b}, {5'd31, 6'd63, 5'd31});
            if (k == 62)  check("pat_bar1", {p_r, p_g, p_b}, {5'd31, 6'd63, 5'd0});
            if (k == 302) check("pat_bar5", {p_r, p_g, p_b}, {5'd31, 6'd0, 5'd0});
            if (k == 421) check("pat_bar6", {p_r, p_g, p_b}, {5'd0, 6'd0, 5'd31});
            if (k == 421) check("pat_de_on", p_de, 1);
            if (k == 490) check("pat_blank", {p_r, p_g, p_b}, 0);
            if (k == 490) check("pat_de_off", p_de, 0);
`endif
        end
        check("a_hsync_low_clocks", a_hs_lo, 60);
        check("a_vsync_low_clocks", a_vs_lo, 92);
        check("a_de_high_clocks", a_de_hi, 192);
        check("a_sof_count", a_sof_n, 2);
        check("b_hsync_low_clocks", b_hs_lo, 60);
        check("b_de_high_clocks", b_de_hi, 192);
        check("c_vsync_high_clocks", c_vs_hi, 92);
        check("c_hsync_high_clocks", c_hs_hi, 60);
        check("b_hsync_fall_x", b_fall_x, 18);
        check("c_hsync_shift", c_rise_k - b_fall_k, 3);
        check("c_de_fall_x", c_de_fall_x, 19);
        check("d_hsync_fall_x", d_fall_x, 482);
        check("p_hsync_fall_x", p_fall_x, 484);
        check("p_hsync_low_line", p_hs_lo, 41);
        check("p_de_high_line", p_de_hi, 480);

        repeat (10) tick();
        check("pre_hold_x", a_x, 10);
        check("pre_hold_y", a_y, 3);
        i_en = 1'b0;
        tick();
        check("hold_x", a_x, 0);
        check("hold_y", a_y, 0);
        check("hold_de_pipe", a_de, 1);
        check("hold_sof", a_sof, 0);
        check("hold_de_nodly", b_de, 0);
        tick();
        check("hold_de_drained", a_de, 0);
        repeat (18) tick();
        check("hold_frame", a_fr, 2);
        check("hold_x_late", a_x, 0);
        check("hold_hsync", a_hs, 1);
        i_en = 1'b1;
        #1;
        check("resume_sof", a_sof, 1);
        check("resume_x", a_x, 0);
        check("resume_y", a_y, 0);

        repeat (50) tick();
        check("pre_rst_x", a_x, 4);
        check("pre_rst_y", a_y, 2);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_x", a_x, 0);
        check("mid_rst_y", a_y, 0);
        check("mid_rst_frame", a_fr, 0);
        check("mid_rst_sof", a_sof, 0);
        check("mid_rst_hsync", a_hs, 1);
        check("mid_rst_vsync", a_vs, 1);
        check("mid_rst_de", a_de, 0);
        repeat (5) tick();
        check("rst_held_sof", a_sof, 0);
        i_rst_n = 1'b1;
        #1;
        check("rst_rel_sof", a_sof, 1);
        check("rst_rel_x", a_x, 0);
        check("rst_rel_y", a_y, 0);
        tick();
        check("rst_rel_next_x", a_x, 1);
        check("rst_rel_next_sof", a_sof, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
